// File: rtl/display_pkg.sv
// Shared types and defaults for the display raster sequencer.
package display_pkg;

  localparam int unsigned CNT_W_DEF        = 10;
  localparam int unsigned PIX_PER_WORD_DEF = 4;
  localparam int unsigned SEL_W_DEF        = 2;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned UCNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } disp_state_e;

endpackage

// File: rtl/display_timing_ctrl_if.sv
// Pixel-stream side of the raster sequencer: FIFO pop handshake and raster status.
interface display_timing_ctrl_if #(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned SEL_W = 2
);

  logic             fifo_empty;
  logic             fifo_rd;
  logic             pix_valid;
  logic [SEL_W-1:0] pix_sel;
  logic             hblank;
  logic             vblank;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] line_y;
  logic             frame_start;
  logic             frame_done;

  modport master (
    input  fifo_empty,
    output fifo_rd, pix_valid, pix_sel, hblank, vblank,
           pixel_x, line_y, frame_start, frame_done
  );

  modport slave (
    output fifo_empty,
    input  fifo_rd, pix_valid, pix_sel, hblank, vblank,
           pixel_x, line_y, frame_start, frame_done
  );

endinterface

// File: rtl/display_timing_ctrl_timing_counter.sv
// x/y raster position counter pair; x wraps at i_x_last, y advances on each x wrap.
module timing_counter #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_x_last,
  input  logic [CNT_W-1:0] i_y_last,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_x_tc_c,
  output logic             o_y_tc_c
);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_x_tc_c = (r_x == i_x_last);
  assign o_y_tc_c = (r_y == i_y_last);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_run) begin
      if (o_x_tc_c) begin
        r_x <= '0;
        r_y <= o_y_tc_c ? '0 : r_y + CNT_W'(1);
      end else begin
        r_x <= r_x + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_timing_ctrl.sv
// Raster sequencer: walks active/blank regions, pops frame-data words, flags underruns.
// Optional build macro UNDERRUN_COUNT_EN adds a saturating 16-bit underrun event counter.
module display_timing_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF,
  parameter int unsigned SEL_W        = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    CSDisplay,
  input  logic [CNT_W-1:0]        HBOut_PD,
  input  logic [CNT_W-1:0]        VBOut_PD,
  input  logic [CNT_W-1:0]        AIPOut_PD,
  input  logic [CNT_W-1:0]        AILOut_PD,
  display_timing_ctrl_if.master   pix_bus,
  output logic                    underrun,
`ifdef UNDERRUN_COUNT_EN
  output logic [UCNT_W-1:0]       underrun_cnt,
`endif
  output logic                    config_err
);

  disp_state_e      r_state;
  disp_state_e      w_state_nxt;

  logic [CNT_W-1:0] r_aip;
  logic [CNT_W-1:0] r_hb;
  logic [CNT_W-1:0] r_ail;
  logic [CNT_W-1:0] r_vb;

  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic [CNT_W-1:0] w_x_last;
  logic [CNT_W-1:0] w_y_last;
  logic             w_x_tc;
  logic             w_y_tc;
  logic             w_x_act_last;
  logic             w_y_act_last;
  logic             w_frame_end;
  logic             w_cfg_ok;
  logic [SEL_W-1:0] w_slot;

  logic             w_latch;
  logic             w_clear;
  logic             w_run;
  logic             w_cfg_err_c;
  logic             w_frame_done_c;
  logic             w_fetch_c;

  logic             r_fifo_rd;
  logic             r_pix_valid;
  logic [SEL_W-1:0] r_pix_sel;
  logic             r_hblank;
  logic             r_vblank;
  logic [CNT_W-1:0] r_pixel_x;
  logic [CNT_W-1:0] r_line_y;
  logic             r_frame_start;
  logic             r_frame_done;
  logic             r_underrun;
  logic             r_config_err;

  // Line/frame extents derived from the timing latched at frame start
  assign w_x_last     = CNT_W'(r_aip + r_hb - CNT_W'(1));
  assign w_y_last     = CNT_W'(r_ail + r_vb - CNT_W'(1));
  assign w_x_act_last = (w_x == CNT_W'(r_aip - CNT_W'(1)));
  assign w_y_act_last = (w_y == CNT_W'(r_ail - CNT_W'(1)));
  assign w_frame_end  = w_x_tc && w_y_tc;
  assign w_cfg_ok     = (AIPOut_PD != '0) && (AILOut_PD != '0);
  assign w_slot       = SEL_W'(w_x & CNT_W'(PIX_PER_WORD - 1));
  assign w_fetch_c    = (r_state == ST_ACTIVE) && (w_slot == '0);

  timing_counter #(
    .CNT_W (CNT_W)
  ) u_timing_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .i_x_last (w_x_last),
    .i_y_last (w_y_last),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_x_tc_c (w_x_tc),
    .o_y_tc_c (w_y_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    w_clear        = 1'b0;
    w_run          = 1'b0;
    w_cfg_err_c    = 1'b0;
    w_frame_done_c = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (CSDisplay) begin
          if (w_cfg_ok) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_cfg_err_c = 1'b1;
          end
        end
      end
      default: begin
        if (w_frame_end) begin
          // Back-to-back frames restart with no idle gap when still enabled
          w_frame_done_c = 1'b1;
          w_clear        = 1'b1;
          if (CSDisplay && w_cfg_ok) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_cfg_err_c = CSDisplay;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_run = 1'b1;
          if (w_x_tc) begin
            w_state_nxt = ((r_state != ST_VBLANK) && !w_y_act_last) ? ST_ACTIVE : ST_VBLANK;
          end else if ((r_state == ST_ACTIVE) && w_x_act_last) begin
            w_state_nxt = ST_HBLANK;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aip <= '0;
      r_hb  <= '0;
      r_ail <= '0;
      r_vb  <= '0;
    end else if (w_latch) begin
      r_aip <= AIPOut_PD;
      r_hb  <= HBOut_PD;
      r_ail <= AILOut_PD;
      r_vb  <= VBOut_PD;
    end
  end

  // Registered raster outputs: one-cycle image of the current state and position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_rd     <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_sel     <= '0;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_pixel_x     <= '0;
      r_line_y      <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
      r_config_err  <= 1'b0;
    end else begin
      r_fifo_rd     <= w_fetch_c && !pix_bus.fifo_empty;
      r_pix_valid   <= (r_state == ST_ACTIVE);
      r_pix_sel     <= (r_state == ST_ACTIVE) ? w_slot : '0;
      r_hblank      <= (r_state == ST_HBLANK) || ((r_state == ST_VBLANK) && (w_x >= r_aip));
      r_vblank      <= (r_state == ST_VBLANK);
      r_pixel_x     <= (r_state == ST_IDLE) ? '0 : w_x;
      r_line_y      <= (r_state == ST_IDLE) ? '0 : w_y;
      r_frame_start <= (r_state == ST_ACTIVE) && (w_x == '0) && (w_y == '0);
      r_frame_done  <= w_frame_done_c;
      r_underrun    <= r_underrun || (w_fetch_c && pix_bus.fifo_empty);
      r_config_err  <= w_cfg_err_c;
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [UCNT_W-1:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun_cnt <= '0;
    end else if (w_fetch_c && pix_bus.fifo_empty && (r_underrun_cnt != {UCNT_W{1'b1}})) begin
      r_underrun_cnt <= r_underrun_cnt + UCNT_W'(1);
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign pix_bus.fifo_rd     = r_fifo_rd;
  assign pix_bus.pix_valid   = r_pix_valid;
  assign pix_bus.pix_sel     = r_pix_sel;
  assign pix_bus.hblank      = r_hblank;
  assign pix_bus.vblank      = r_vblank;
  assign pix_bus.pixel_x     = r_pixel_x;
  assign pix_bus.line_y      = r_line_y;
  assign pix_bus.frame_start = r_frame_start;
  assign pix_bus.frame_done  = r_frame_done;
  assign underrun            = r_underrun;
  assign config_err          = r_config_err;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Randomized bench for display_timing_ctrl against a frame-index reference model.
module tb_display_timing_ctrl;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned PPW   = 4;
  localparam int unsigned SEL_W = 2;

  logic             clk;
  logic             reset;
  logic             cs;
  logic [CNT_W-1:0] hb_in, vb_in, aip_in, ail_in;
  logic             underrun;
  logic             config_err;
`ifdef UNDERRUN_COUNT_EN
  logic [15:0]      underrun_cnt;
`endif

  display_timing_ctrl_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  display_timing_ctrl #(
    .CNT_W        (CNT_W),
    .PIX_PER_WORD (PPW),
    .SEL_W        (SEL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .CSDisplay    (cs),
    .HBOut_PD     (hb_in),
    .VBOut_PD     (vb_in),
    .AIPOut_PD    (aip_in),
    .AILOut_PD    (ail_in),
    .pix_bus      (bus),
    .underrun     (underrun),
`ifdef UNDERRUN_COUNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .config_err   (config_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: a running frame is a linear cycle index k; x = k mod L, y = k div L
  bit m_run;
  int m_k;
  int m_aip, m_hb, m_ail, m_vb;
  bit e_rd, e_pv, e_hb, e_vb, e_fs, e_fd, e_ur, e_cfg;
  int e_sel, e_px, e_ly, e_ucnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    bit good, bad, fetch;
    int len, flen, x, y;
    good = cs && (aip_in != 0) && (ail_in != 0);
    bad  = cs && !good;
    if (reset) begin
      m_run = 0; m_k = 0;
      {e_rd, e_pv, e_hb, e_vb, e_fs, e_fd, e_ur, e_cfg} = '0;
      e_sel = 0; e_px = 0; e_ly = 0; e_ucnt = 0;
    end else if (!m_run) begin
      {e_rd, e_pv, e_hb, e_vb, e_fs, e_fd} = '0;
      e_sel = 0; e_px = 0; e_ly = 0;
      e_cfg = bad;
      if (good) begin
        m_aip = int'(aip_in); m_hb = int'(hb_in); m_ail = int'(ail_in); m_vb = int'(vb_in);
        m_run = 1; m_k = 0;
      end
    end else begin
      len   = m_aip + m_hb;
      flen  = len * (m_ail + m_vb);
      x     = m_k % len;
      y     = m_k / len;
      e_pv  = (y < m_ail) && (x < m_aip);
      e_sel = e_pv ? (x % int'(PPW)) : 0;
      e_hb  = (x >= m_aip);
      e_vb  = (y >= m_ail);
      e_px  = x;
      e_ly  = y;
      e_fs  = (m_k == 0);
      e_fd  = (m_k == flen - 1);
      fetch = e_pv && (e_sel == 0);
      e_rd  = fetch && !bus.fifo_empty;
      if (fetch && bus.fifo_empty) begin
        e_ur = 1;
        if (e_ucnt != 16'hFFFF) e_ucnt++;
      end
      e_cfg = e_fd && bad;
      if (e_fd) begin
        m_k = 0;
        if (good) begin
          m_aip = int'(aip_in); m_hb = int'(hb_in); m_ail = int'(ail_in); m_vb = int'(vb_in);
        end else begin
          m_run = 0;
        end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic compare_all();
    check("fifo_rd",     32'(bus.fifo_rd),     32'(e_rd));
    check("pix_valid",   32'(bus.pix_valid),   32'(e_pv));
    check("pix_sel",     32'(bus.pix_sel),     32'(e_sel));
    check("hblank",      32'(bus.hblank),      32'(e_hb));
    check("vblank",      32'(bus.vblank),      32'(e_vb));
    check("pixel_x",     32'(bus.pixel_x),     32'(e_px));
    check("line_y",      32'(bus.line_y),      32'(e_ly));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("frame_done",  32'(bus.frame_done),  32'(e_fd));
    check("underrun",    32'(underrun),        32'(e_ur));
    check("config_err",  32'(config_err),      32'(e_cfg));
`ifdef UNDERRUN_COUNT_EN
    check("underrun_cnt", 32'(underrun_cnt),   32'(e_ucnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    cyc++;
  endtask

  task automatic set_cfg(input int aip, input int hb, input int ail, input int vb);
    aip_in = CNT_W'(aip); hb_in = CNT_W'(hb); ail_in = CNT_W'(ail); vb_in = CNT_W'(vb);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int  fs_cnt, fs1, fs2, pv_cnt, rd_cnt, fd_off, low_cnt, cfg_cnt, fd_cnt;
  bit  seen, done;

  initial begin
    reset = 1'b1; cs = 1'b0; bus.fifo_empty = 1'b0;
    set_cfg(0, 0, 0, 0);
    m_run = 0; m_k = 0; m_aip = 0; m_hb = 0; m_ail = 0; m_vb = 0;
    step(); step();

    // Nominal frame: 8 px + 2 blank, 4 active + 1 blank line
    reset = 1'b0; set_cfg(8, 2, 4, 1); cs = 1'b1;
    fs_cnt = 0; fs1 = 0; fs2 = 0; pv_cnt = 0; rd_cnt = 0; fd_off = -1;
    for (int i = 0; i < 130; i++) begin
      step();
      if (bus.frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs1 = cyc;
        if (fs_cnt == 2) fs2 = cyc;
      end
      if (fs_cnt == 1) begin
        pv_cnt += int'(bus.pix_valid);
        rd_cnt += int'(bus.fifo_rd);
        if (bus.frame_done) fd_off = cyc - fs1;
      end
    end
    check("frame_period",  32'(fs2 - fs1), 32'd50);
    check("frame_pv_cnt",  32'(pv_cnt),    32'd32);
    check("frame_rd_cnt",  32'(rd_cnt),    32'd8);
    check("frame_done_at", 32'(fd_off),    32'd49);

    // No blanking: pixel stream must be gapless across frames
    do_reset();
    set_cfg(8, 0, 4, 0);
    seen = 0; low_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      if (bus.pix_valid) seen = 1;
      else if (seen) low_cnt++;
    end
    check("pv_seen",       32'(seen),    32'd1);
    check("pv_gapless",    32'(low_cnt), 32'd0);

    // Zero active pixels: config_err every cycle, no fetch
    do_reset();
    set_cfg(0, 2, 4, 1);
    cfg_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cfg_cnt += int'(config_err);
      rd_cnt  += int'(bus.fifo_rd);
    end
    check("cfg_err_cnt",   32'(cfg_cnt), 32'd6);
    check("cfg_no_rd",     32'(rd_cnt),  32'd0);

    // FIFO empty on line 1 word 0
    do_reset();
    set_cfg(8, 2, 4, 1);
    for (int i = 0; i < 120; i++) begin
      bus.fifo_empty = m_run && (m_k == 10);
      step();
    end
    bus.fifo_empty = 1'b0;
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Disable during line 2: frame completes, then idle
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_run && (m_k == 20)) cs = 1'b0;
      step();
      fd_cnt += int'(bus.frame_done);
    end
    check("drop_fd_cnt",   32'(fd_cnt),          32'd1);
    check("drop_idle_pv",  32'(bus.pix_valid),   32'd0);

    // Reset mid-active at x=3
    cs = 1'b1;
    do_reset();
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m_run && (m_k == 3)) begin
        do_reset();
        check("rst_mid_pv", 32'(bus.pix_valid), 32'd0);
        done = 1;
      end else begin
        step();
      end
    end
    check("rst_mid_hit", 32'(done), 32'd1);
    for (int i = 0; i < 60; i++) step();

    // Randomized traffic with config changes, enable toggles, resets and FIFO stalls
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 99) == 0) cs = ~cs;
      if ($urandom_range(0, 39) == 0) begin
        set_cfg(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 2)));
      end
      bus.fifo_empty = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
